inst_bus_arbiter: RTL and testbench
===================================

// Module: inst_bus_arbiter
//
// PURPOSE
//   Shares one instruction-memory port (addr/inst/busy slave) between two requesters.
//   Master 0 is the fetch stage. Master 1 is the debug/loader port.
//   Each access is a registered req/ack transaction. Arbitration is round-robin.
//   A wait-state watchdog aborts accesses when the memory holds busy too long.
//   Sits between the fetch/debug logic and the instruction memory model.
//
// PARAMETERS
//   ADDR_WIDTH  32  address width in bits (byte address, passed through unchanged)
//   DATA_WIDTH  32  instruction word width
//   TIMEOUT     15  max consecutive busy cycles before abort; 0 = watchdog disabled
//
// PORTS
//   i_clock     in   1           clock, rising edge
//   i_reset     in   1           synchronous reset, active-high
//   i_m0_req    in   1           master 0 request; held until o_m0_ack
//   i_m0_addr   in   ADDR_WIDTH  master 0 address; stable while i_m0_req=1
//   o_m0_ack    out  1           one-cycle completion pulse to master 0
//   o_m0_err    out  1           high with o_m0_ack when the access timed out
//   o_m0_data   out  DATA_WIDTH  read data; valid when o_m0_ack=1, then held
//   i_m1_req, i_m1_addr, o_m1_ack, o_m1_err, o_m1_data: same as m0, for master 1
//   o_mem_req   out  1           access strobe to memory
//   o_mem_addr  out  ADDR_WIDTH  address to memory
//   i_mem_inst  in   DATA_WIDTH  instruction word from memory
//   i_mem_busy  in   1           memory wait state; data is sampled only when 0
//
// BEHAVIOUR
//   - Reset values:
//       all outputs 0; state=IDLE; last=1 (m0 wins the first tie);
//       wait counter=0; latched addr=0; owner=0.
//   - IDLE:
//       if any req: pick winner, latch its addr into o_mem_addr, owner<=winner, cnt<=0,
//       then go to ACCESS.
//       Only m0 req -> m0; only m1 req -> m1; both -> the master != last.
//   - ACCESS:
//       o_mem_req=1; o_mem_addr=latched addr.
//       i_mem_busy=0: owner's o_data<=i_mem_inst, err<=0, go to DONE.
//       i_mem_busy=1, TIMEOUT!=0, cnt==TIMEOUT-1: owner's o_data<=0, err<=1, go to DONE.
//       Otherwise cnt<=cnt+1 (saturating; never wraps).
//   - DONE:
//       owner's o_ack=1 (and o_err if flagged) for exactly one cycle;
//       last<=owner; go to IDLE.
//   - Non-owner outputs never change during another master's transaction.
//   - o_mem_addr holds its last value outside ACCESS. o_mem_req=0 outside ACCESS.
//   - Latency:
//       req sampled in cycle N -> ACCESS in N+1 -> ack in N+2 (zero wait states);
//       each busy cycle adds 1.
//       Max throughput is 1 access per 3 cycles.
//   - Masters must drop req or present a new request at the edge ending the ack cycle.
//     IDLE samples it fresh, so back-to-back requests are allowed.
//   - req deasserted mid-transaction: ignored; the access completes and ack is still issued.
//   - Address changed mid-transaction: ignored; the latched address is used.
//   - Reset mid-transaction: immediate return to IDLE; no ack or err is issued;
//     o_data clears to 0.
//   - Timeout data is forced to 0. The memory is not retried.
//
// TESTING
//   1 Only m0 req at addr 0x100, busy=0, mem returns 0x00000013
//     -> o_mem_req high 1 cycle; o_m0_ack 2 cycles after req; o_m0_data=0x13; o_m1_ack=0.
//   2 m0 and m1 request together, held continuously
//     -> grants alternate m0,m1,m0,m1; ack every 3rd cycle.
//   3 m1 req, busy high 4 cycles, TIMEOUT=15
//     -> o_m1_ack at req+6; data correct; o_m1_err=0.
//   4 m0 req, busy stuck high, TIMEOUT=15
//     -> o_m0_ack and o_m0_err at cycle req+16; o_m0_data=0.
//     Same test with TIMEOUT=0 -> no ack ever.
//   5 i_reset asserted in ACCESS with busy=1
//     -> next cycle all outputs 0; no ack.
//     After reset, simultaneous requests -> m0 wins first.
//   6 m0 drops req and changes addr to 0x200 during ACCESS
//     -> o_mem_addr stays 0x100; ack still issued; the next IDLE does not grant m0.

Source files
------------

// File: rtl/inst_bus_arbiter.sv
// Two-master round-robin arbiter in front of a single instruction-memory port.
// A busy-cycle watchdog ends an access with an error when the memory stalls too long.
module inst_bus_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 15
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_m0_req,
  input  logic [ADDR_WIDTH-1:0] i_m0_addr,
  output logic                  o_m0_ack,
  output logic                  o_m0_err,
  output logic [DATA_WIDTH-1:0] o_m0_data,
  input  logic                  i_m1_req,
  input  logic [ADDR_WIDTH-1:0] i_m1_addr,
  output logic                  o_m1_ack,
  output logic                  o_m1_err,
  output logic [DATA_WIDTH-1:0] o_m1_data,
  output logic                  o_mem_req,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  input  logic [DATA_WIDTH-1:0] i_mem_inst,
  input  logic                  i_mem_busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  // The counter only ever needs to reach TIMEOUT-1; it saturates rather than wrapping.
  localparam int              CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic             WDOG_ON  = (TIMEOUT != 0) ? 1'b1 : 1'b0;

  state_t                state_r;
  state_t                nextState_s;
  logic                  owner_r;
  logic                  last_r;
  logic [CNT_W-1:0]      waitCnt_r;
  logic [ADDR_WIDTH-1:0] memAddr_r;
  logic                  memReq_r;
  logic                  ack0_r;
  logic                  ack1_r;
  logic                  err0_r;
  logic                  err1_r;
  logic [DATA_WIDTH-1:0] data0_r;
  logic [DATA_WIDTH-1:0] data1_r;

  logic                  anyReq_s;
  logic                  grant_s;
  logic                  finish_s;
  logic                  expire_s;

  // Winner selection and next-state decode
  always_comb begin
    nextState_s = state_r;
    finish_s    = 1'b0;
    expire_s    = 1'b0;
    anyReq_s    = i_m0_req | i_m1_req;
    if (i_m0_req && i_m1_req) begin
      grant_s = ~last_r;
    end else if (i_m1_req) begin
      grant_s = 1'b1;
    end else begin
      grant_s = 1'b0;
    end
    case (state_r)
      IDLE: begin
        if (anyReq_s) begin
          nextState_s = ACCESS;
        end else begin
          nextState_s = IDLE;
        end
      end
      ACCESS: begin
        if (!i_mem_busy) begin
          finish_s    = 1'b1;
          nextState_s = DONE;
        end else if (WDOG_ON && (waitCnt_r == CNT_LAST)) begin
          finish_s    = 1'b1;
          expire_s    = 1'b1;
          nextState_s = DONE;
        end else begin
          nextState_s = ACCESS;
        end
      end
      DONE: begin
        nextState_s = IDLE;
      end
      default: begin
        nextState_s = IDLE;
      end
    endcase
  end

  // State, ownership, fairness pointer, wait counter and memory-side strobe
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_r   <= IDLE;
      owner_r   <= 1'b0;
      last_r    <= 1'b1;
      waitCnt_r <= '0;
      memAddr_r <= '0;
      memReq_r  <= 1'b0;
    end else begin
      state_r  <= nextState_s;
      memReq_r <= (nextState_s == ACCESS);
      if ((state_r == IDLE) && anyReq_s) begin
        owner_r   <= grant_s;
        memAddr_r <= grant_s ? i_m1_addr : i_m0_addr;
        waitCnt_r <= '0;
      end else if ((state_r == ACCESS) && !finish_s && (waitCnt_r != CNT_MAX)) begin
        waitCnt_r <= waitCnt_r + CNT_ONE;
      end
      if (state_r == DONE) begin
        last_r <= owner_r;
      end
    end
  end

  // Per-master completion signalling; the non-owner's registers are left untouched
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      ack0_r  <= 1'b0;
      ack1_r  <= 1'b0;
      err0_r  <= 1'b0;
      err1_r  <= 1'b0;
      data0_r <= '0;
      data1_r <= '0;
    end else begin
      ack0_r <= finish_s & ~owner_r;
      ack1_r <= finish_s & owner_r;
      err0_r <= expire_s & ~owner_r;
      err1_r <= expire_s & owner_r;
      if (finish_s && !owner_r) begin
        data0_r <= expire_s ? '0 : i_mem_inst;
      end
      if (finish_s && owner_r) begin
        data1_r <= expire_s ? '0 : i_mem_inst;
      end
    end
  end

  assign o_m0_ack   = ack0_r;
  assign o_m0_err   = err0_r;
  assign o_m0_data  = data0_r;
  assign o_m1_ack   = ack1_r;
  assign o_m1_err   = err1_r;
  assign o_m1_data  = data1_r;
  assign o_mem_req  = memReq_r;
  assign o_mem_addr = memAddr_r;

endmodule

// File: tb/tb_inst_bus_arbiter.sv
// Self-checking bench for inst_bus_arbiter: directed scenarios with literal expectations,
// then randomized traffic, all cross-checked every cycle against a transaction-level model.
module tb_inst_bus_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 15;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          m0Req, m1Req, memBusy;
  logic [AW-1:0] m0Addr, m1Addr;
  logic [DW-1:0] memInst;
  logic          ack0, err0, ack1, err1, memReq;
  logic [DW-1:0] data0, data1;
  logic [AW-1:0] memAddr;

  logic          zReq, zBusy;
  logic          zAck0, zErr0, zAck1, zErr1, zMemReq;
  logic [DW-1:0] zData0, zData1;
  logic [AW-1:0] zMemAddr;

  inst_bus_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .i_clock(clk), .i_reset(rst),
    .i_m0_req(m0Req), .i_m0_addr(m0Addr), .o_m0_ack(ack0), .o_m0_err(err0), .o_m0_data(data0),
    .i_m1_req(m1Req), .i_m1_addr(m1Addr), .o_m1_ack(ack1), .o_m1_err(err1), .o_m1_data(data1),
    .o_mem_req(memReq), .o_mem_addr(memAddr), .i_mem_inst(memInst), .i_mem_busy(memBusy)
  );

  // Watchdog-disabled instance, used only for the stuck-busy case
  inst_bus_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(0)) dutNoWd (
    .i_clock(clk), .i_reset(rst),
    .i_m0_req(zReq), .i_m0_addr(32'h0000_0140), .o_m0_ack(zAck0), .o_m0_err(zErr0), .o_m0_data(zData0),
    .i_m1_req(1'b0), .i_m1_addr(32'h0000_0000), .o_m1_ack(zAck1), .o_m1_err(zErr1), .o_m1_data(zData1),
    .o_mem_req(zMemReq), .o_mem_addr(zMemAddr), .i_mem_inst(32'h0000_0000), .i_mem_busy(zBusy)
  );

  int checks = 0;
  int errors = 0;

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkW(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level reference: one access in flight, served from grant to ack, then one idle cycle
  bit            mValid = 1'b0;
  bit            mActive, mDone, mOwner, mLast;
  int            mWaited;
  logic          expMemReq;
  logic [AW-1:0] expMemAddr;
  logic          expAck [2];
  logic          expErr [2];
  logic [DW-1:0] expData [2];

  always @(posedge clk) begin
    if (rst) begin
      mValid = 1'b1; mActive = 1'b0; mDone = 1'b0; mLast = 1'b1; mOwner = 1'b0; mWaited = 0;
      expMemReq = 1'b0; expMemAddr = '0;
      for (int i = 0; i < 2; i++) begin
        expAck[i] = 1'b0; expErr[i] = 1'b0; expData[i] = '0;
      end
    end else if (mValid) begin
      expAck[0] = 1'b0; expAck[1] = 1'b0; expErr[0] = 1'b0; expErr[1] = 1'b0;
      expMemReq = 1'b0;
      if (mDone) begin
        mDone = 1'b0;
        mLast = mOwner;
      end else if (mActive) begin
        if (!memBusy) begin
          expData[mOwner] = memInst;
          expAck[mOwner]  = 1'b1;
          mActive = 1'b0; mDone = 1'b1;
        end else if (TO != 0 && mWaited + 1 == TO) begin
          expData[mOwner] = '0;
          expAck[mOwner]  = 1'b1;
          expErr[mOwner]  = 1'b1;
          mActive = 1'b0; mDone = 1'b1;
        end else begin
          mWaited++;
        end
        expMemReq = mActive;
      end else if (m0Req || m1Req) begin
        mOwner     = (m0Req && m1Req) ? !mLast : m1Req;
        expMemAddr = mOwner ? m1Addr : m0Addr;
        mActive    = 1'b1;
        mWaited    = 0;
        expMemReq  = 1'b1;
      end
    end
  end

  // Every-cycle comparison of the main instance against the model
  always @(negedge clk) begin
    if (mValid) begin
      check1("m0_ack", ack0, expAck[0]);
      check1("m0_err", err0, expErr[0]);
      checkW("m0_data", data0, expData[0]);
      check1("m1_ack", ack1, expAck[1]);
      check1("m1_err", err1, expErr[1]);
      checkW("m1_data", data1, expData[1]);
      check1("mem_req", memReq, expMemReq);
      checkW("mem_addr", memAddr, expMemAddr);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic pulseReset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  int busyRun;

  initial begin
    rst = 1'b1; m0Req = 1'b0; m1Req = 1'b0; m0Addr = '0; m1Addr = '0;
    memInst = '0; memBusy = 1'b0; zReq = 1'b0; zBusy = 1'b0;
    tick(); tick();
    check1("rst_ack0", ack0, 1'b0);
    check1("rst_memreq", memReq, 1'b0);
    checkW("rst_memaddr", memAddr, 32'h0000_0000);
    checkW("rst_data0", data0, 32'h0000_0000);
    rst = 1'b0;

    // Single m0 access, zero wait states
    m0Req = 1'b1; m0Addr = 32'h0000_0100; memInst = 32'h0000_0013; memBusy = 1'b0;
    tick();
    check1("t1_memreq", memReq, 1'b1);
    checkW("t1_memaddr", memAddr, 32'h0000_0100);
    check1("t1_ack_early", ack0, 1'b0);
    tick();
    check1("t1_ack", ack0, 1'b1);
    checkW("t1_data", data0, 32'h0000_0013);
    check1("t1_ack1", ack1, 1'b0);
    check1("t1_memreq_off", memReq, 1'b0);
    m0Req = 1'b0;
    tick();
    check1("t1_ack_off", ack0, 1'b0);
    checkW("t1_data_held", data0, 32'h0000_0013);

    // Stuck busy: watchdog aborts on the main instance, never completes without it
    m0Req = 1'b1; m0Addr = 32'h0000_0140; memBusy = 1'b1; memInst = 32'hDEAD_BEEF;
    zReq = 1'b1; zBusy = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (k < 16) check1("t4_ack_early", ack0, 1'b0);
      if (k == 16) begin
        check1("t4_ack", ack0, 1'b1);
        check1("t4_err", err0, 1'b1);
        checkW("t4_data", data0, 32'h0000_0000);
        m0Req = 1'b0;
      end
      check1("t4_nowd_ack", zAck0, 1'b0);
    end
    check1("t4_nowd_memreq", zMemReq, 1'b1);
    memBusy = 1'b0; zReq = 1'b0;

    // Both masters held: grants alternate starting with m0
    pulseReset();
    m0Req = 1'b1; m1Req = 1'b1; m0Addr = 32'h0000_1000; m1Addr = 32'h0000_2000;
    memInst = 32'hA000_0000;
    for (int k = 1; k <= 12; k++) begin
      tick();
      check1("t2_ack0", ack0, (k % 6) == 2);
      check1("t2_ack1", ack1, (k % 6) == 5);
      if (k == 2)  checkW("t2_data0a", data0, 32'hA000_0001);
      if (k == 5)  checkW("t2_data1a", data1, 32'hA000_0004);
      if (k == 8)  checkW("t2_data0b", data0, 32'hA000_0007);
      if (k == 11) begin
        checkW("t2_data1b", data1, 32'hA000_000A);
        m0Req = 1'b0; m1Req = 1'b0;
      end
      memInst = 32'hA000_0000 + 32'(k);
    end

    // m1 with four busy cycles
    pulseReset();
    m1Req = 1'b1; m1Addr = 32'h0000_0180; memBusy = 1'b1; memInst = 32'h0BAD_F00D;
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (k < 6) check1("t3_ack_early", ack1, 1'b0);
      else begin
        check1("t3_ack", ack1, 1'b1);
        check1("t3_err", err1, 1'b0);
        checkW("t3_data", data1, 32'h0BAD_F00D);
        m1Req = 1'b0;
      end
      if (k == 5) memBusy = 1'b0;
    end

    // m0 drops req and changes addr mid-access; m1 then wins the tie
    pulseReset();
    m0Req = 1'b1; m0Addr = 32'h0000_0100; memBusy = 1'b1; memInst = 32'h1111_2222;
    for (int k = 1; k <= 9; k++) begin
      tick();
      case (k)
        1: begin
          checkW("t6_addr1", memAddr, 32'h0000_0100);
          m0Req = 1'b0; m0Addr = 32'h0000_0200; m1Req = 1'b1; m1Addr = 32'h0000_0300;
        end
        2: begin
          checkW("t6_addr2", memAddr, 32'h0000_0100);
          memBusy = 1'b0;
        end
        3: begin
          check1("t6_ack0", ack0, 1'b1);
          checkW("t6_data0", data0, 32'h1111_2222);
          m0Req = 1'b1; m0Addr = 32'h0000_0400;
        end
        5: checkW("t6_grant_m1", memAddr, 32'h0000_0300);
        6: begin
          check1("t6_ack1", ack1, 1'b1);
          m1Req = 1'b0;
        end
        8: checkW("t6_grant_m0", memAddr, 32'h0000_0400);
        9: begin
          check1("t6_ack0b", ack0, 1'b1);
          m0Req = 1'b0;
        end
        default: ;
      endcase
    end

    // Reset during a stalled access, then a tie goes to m0
    m0Req = 1'b1; m0Addr = 32'h0000_0500; memBusy = 1'b1; memInst = 32'h5555_AAAA;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k == 2) rst = 1'b1;
      if (k == 3) begin
        check1("t5_memreq", memReq, 1'b0);
        check1("t5_ack0", ack0, 1'b0);
        check1("t5_err0", err0, 1'b0);
        checkW("t5_data0", data0, 32'h0000_0000);
        checkW("t5_memaddr", memAddr, 32'h0000_0000);
        rst = 1'b0; m1Req = 1'b1; m1Addr = 32'h0000_0600; memBusy = 1'b0;
      end
      if (k == 4) checkW("t5_first_m0", memAddr, 32'h0000_0500);
      if (k == 5) begin
        check1("t5_ack0b", ack0, 1'b1);
        check1("t5_ack1b", ack1, 1'b0);
        checkW("t5_data0b", data0, 32'h5555_AAAA);
        m0Req = 1'b0;
      end
      if (k == 8) begin
        check1("t5_ack1c", ack1, 1'b1);
        m1Req = 1'b0;
      end
    end

    // Randomized traffic, busy bursts long enough to trip the watchdog, occasional resets
    busyRun = 0;
    for (int c = 0; c < 3000; c++) begin
      tick();
      rst = ($urandom_range(0, 299) == 0);
      memInst = $urandom;
      if (busyRun > 0) begin
        memBusy = 1'b1; busyRun--;
      end else if ($urandom_range(0, 49) == 0) begin
        busyRun = $urandom_range(10, 20); memBusy = 1'b1;
      end else begin
        memBusy = ($urandom_range(0, 3) == 0);
      end
      if (m0Req && ack0) m0Req = ($urandom_range(0, 1) == 1);
      else if (!m0Req)   m0Req = ($urandom_range(0, 2) == 0);
      else if ($urandom_range(0, 19) == 0) m0Req = 1'b0;
      if (m1Req && ack1) m1Req = ($urandom_range(0, 1) == 1);
      else if (!m1Req)   m1Req = ($urandom_range(0, 2) == 0);
      else if ($urandom_range(0, 19) == 0) m1Req = 1'b0;
      if ($urandom_range(0, 3) == 0) m0Addr = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 3) == 0) m1Addr = $urandom & 32'hFFFF_FFFC;
    end
    rst = 1'b0; m0Req = 1'b0; m1Req = 1'b0; memBusy = 1'b0;
    repeat (20) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
